// File: rtl/core_dispatcher.sv
// core_dispatcher: hands contiguous nonce blocks to NUM_CORES hash cores in round-robin
// order and folds their results into one global best (lowest bits-off) register.
module core_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int BLOCK_LOG2 = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [255:0]             base_nonce_i,
    input  logic [NUM_CORES-1:0]     work_req_i,
    output logic [NUM_CORES-1:0]     work_grant_o,
    output logic [255:0]             work_nonce_o,
    input  logic [NUM_CORES-1:0]     result_valid_i,
    input  logic [256*NUM_CORES-1:0] result_nonce_i,
    input  logic [10*NUM_CORES-1:0]  result_bits_off_i,
    output logic [NUM_CORES-1:0]     result_ack_o,
    input  logic                     clear_best_i,
    output logic [255:0]             best_nonce_o,
    output logic [9:0]               best_bits_off_o,
    output logic                     best_update_o,
    output logic                     running_o
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PW-1:0] IDX_ZERO = PW'(0);
    localparam logic [PW-1:0] IDX_ONE  = PW'(1);
    localparam logic [PW-1:0] IDX_LAST = PW'(NUM_CORES - 1);
    localparam logic [255:0]  BLOCK_INC = 256'd1 << BLOCK_LOG2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Index that follows idx in circular core order.
    function automatic logic [PW-1:0] succ(input logic [PW-1:0] idx);
        return (idx == IDX_LAST) ? IDX_ZERO : idx + IDX_ONE;
    endfunction

    // Round-robin pick starting at 'first'; returns {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                            input logic [PW-1:0]        first);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = {(PW+1){1'b0}};
        idx = first;
        for (int i = 0; i < NUM_CORES; i++) begin
            res = (!res[PW] && req[idx]) ? {1'b1, idx} : res;
            idx = succ(idx);
        end
        return res;
    endfunction

    function automatic logic [NUM_CORES-1:0] onehot(input logic [PW-1:0] idx);
        logic [NUM_CORES-1:0] res;
        for (int i = 0; i < NUM_CORES; i++) begin
            res[i] = (idx == PW'(i));
        end
        return res;
    endfunction

    state_t               state_r;
    state_t               state_nx_s;
    logic                 grant_en_s;
    logic                 load_base_s;
    logic                 running_nx_s;

    logic [PW-1:0]        work_ptr_r;
    logic [255:0]         next_nonce_r;
    logic [PW:0]          work_pick_s;
    logic                 work_take_s;
    logic [NUM_CORES-1:0] work_grant_nx_s;
    logic [255:0]         work_nonce_nx_s;
    logic [PW-1:0]        work_ptr_nx_s;
    logic [255:0]         next_nonce_nx_s;

    logic [PW-1:0]        res_ptr_r;
    logic [PW:0]          res_pick_s;
    logic                 res_take_s;
    logic [PW-1:0]        res_idx_s;
    logic [255:0]         sel_nonce_s;
    logic [9:0]           sel_bits_s;
    logic [9:0]           cmp_bits_s;
    logic [NUM_CORES-1:0] ack_nx_s;
    logic [PW-1:0]        res_ptr_nx_s;
    logic [255:0]         best_nonce_nx_s;
    logic [9:0]           best_bits_nx_s;
    logic                 best_update_nx_s;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state; stop beats a simultaneous start
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: state_nx_s = (start_i && !stop_i) ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx_s = stop_i ? ST_IDLE : ST_RUN;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs; a stop in the current cycle already blocks the grant
    always_comb begin
        grant_en_s   = (state_r == ST_RUN) && !stop_i;
        load_base_s  = start_i && !stop_i;
        running_nx_s = (state_nx_s == ST_RUN);
    end

    // Work arbiter: the core granted last cycle is masked while its request falls
    always_comb begin
        work_pick_s     = rr_pick(work_req_i & ~work_grant_o, work_ptr_r);
        work_take_s     = grant_en_s && work_pick_s[PW];
        work_grant_nx_s = {NUM_CORES{1'b0}};
        work_nonce_nx_s = work_nonce_o;
        work_ptr_nx_s   = work_ptr_r;
        if (work_take_s) begin
            work_grant_nx_s = onehot(work_pick_s[PW-1:0]);
            work_nonce_nx_s = next_nonce_r;
            work_ptr_nx_s   = succ(work_pick_s[PW-1:0]);
        end else begin
            work_grant_nx_s = {NUM_CORES{1'b0}};
        end
        next_nonce_nx_s = load_base_s ? base_nonce_i :
                          (work_take_s ? next_nonce_r + BLOCK_INC : next_nonce_r);
    end

    // Work arbiter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work_grant_o <= {NUM_CORES{1'b0}};
            work_nonce_o <= 256'd0;
            work_ptr_r   <= IDX_ZERO;
            next_nonce_r <= 256'd0;
            running_o    <= 1'b0;
        end else begin
            work_grant_o <= work_grant_nx_s;
            work_nonce_o <= work_nonce_nx_s;
            work_ptr_r   <= work_ptr_nx_s;
            next_nonce_r <= next_nonce_nx_s;
            running_o    <= running_nx_s;
        end
    end

    // Result collector: select one pending result and fold it into the best
    always_comb begin
        res_pick_s  = rr_pick(result_valid_i & ~result_ack_o, res_ptr_r);
        res_take_s  = res_pick_s[PW];
        res_idx_s   = res_pick_s[PW-1:0];
        sel_nonce_s = 256'd0;
        sel_bits_s  = 10'd0;
        for (int k = 0; k < NUM_CORES; k++) begin
            sel_nonce_s = sel_nonce_s |
                ({256{res_idx_s == PW'(k)}} & result_nonce_i[256*k +: 256]);
            sel_bits_s  = sel_bits_s |
                ({10{res_idx_s == PW'(k)}} & result_bits_off_i[10*k +: 10]);
        end
        cmp_bits_s       = clear_best_i ? 10'h3FF : best_bits_off_o;
        ack_nx_s         = res_take_s ? onehot(res_idx_s) : {NUM_CORES{1'b0}};
        res_ptr_nx_s     = res_take_s ? succ(res_idx_s) : res_ptr_r;
        best_nonce_nx_s  = best_nonce_o;
        best_bits_nx_s   = best_bits_off_o;
        best_update_nx_s = 1'b0;
        // strict less-than keeps the older entry on a tie
        if (res_take_s && (sel_bits_s < cmp_bits_s)) begin
            best_nonce_nx_s  = sel_nonce_s;
            best_bits_nx_s   = sel_bits_s;
            best_update_nx_s = 1'b1;
        end else if (clear_best_i) begin
            best_nonce_nx_s  = 256'd0;
            best_bits_nx_s   = 10'h3FF;
            best_update_nx_s = 1'b0;
        end else begin
            best_update_nx_s = 1'b0;
        end
    end

    // Result collector and global best registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_ack_o    <= {NUM_CORES{1'b0}};
            res_ptr_r       <= IDX_ZERO;
            best_nonce_o    <= 256'd0;
            best_bits_off_o <= 10'h3FF;
            best_update_o   <= 1'b0;
        end else begin
            result_ack_o    <= ack_nx_s;
            res_ptr_r       <= res_ptr_nx_s;
            best_nonce_o    <= best_nonce_nx_s;
            best_bits_off_o <= best_bits_nx_s;
            best_update_o   <= best_update_nx_s;
        end
    end

endmodule

// File: tb/tb_core_dispatcher.sv
// Randomized and directed bench for core_dispatcher against a cycle-level reference model.
module tb_core_dispatcher;

    localparam int N  = 4;
    localparam int BL = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, stop, clr;
    logic [255:0]     base;
    logic [N-1:0]     req, rvalid;
    logic [256*N-1:0] rnonce;
    logic [10*N-1:0]  rbits;
    logic [N-1:0]     grant, ack;
    logic [255:0]     wnonce, best_nonce;
    logic [9:0]       best_bits;
    logic             upd, running;

    always #5 clk = ~clk;

    core_dispatcher #(.NUM_CORES(N), .BLOCK_LOG2(BL)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .base_nonce_i(base), .work_req_i(req), .work_grant_o(grant),
        .work_nonce_o(wnonce), .result_valid_i(rvalid), .result_nonce_i(rnonce),
        .result_bits_off_i(rbits), .result_ack_o(ack), .clear_best_i(clr),
        .best_nonce_o(best_nonce), .best_bits_off_o(best_bits),
        .best_update_o(upd), .running_o(running)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: "last" is the most recently served core, "prev" is last cycle's (-1 none)
    bit           m_run;
    logic [255:0] m_next, m_best_nonce, e_wnonce;
    logic [9:0]   m_best_bits;
    int           m_last_w, m_prev_w, m_last_r, m_prev_r;
    logic [N-1:0] e_grant, e_ack;
    bit           e_upd;

    task automatic model_reset();
        m_run = 0; m_next = 256'd0;
        m_last_w = N - 1; m_prev_w = -1; m_last_r = N - 1; m_prev_r = -1;
        m_best_nonce = 256'd0; m_best_bits = 10'h3FF;
        e_grant = '0; e_ack = '0; e_wnonce = 256'd0; e_upd = 0;
    endtask

    task automatic model_step();
        int g, a;
        logic [9:0] bo, cmpv;
        g = -1;
        if (m_run && !stop)
            for (int off = 1; off <= N; off++) begin
                int c = (m_last_w + off) % N;
                if (g < 0 && req[c] && c != m_prev_w) g = c;
            end
        m_prev_w = g;
        e_grant = '0;
        if (g >= 0) begin
            e_grant[g] = 1'b1;
            e_wnonce = m_next;
            m_last_w = g;
            m_next = m_next + (256'd1 << BL);
        end
        if (start && !stop) m_next = base;
        a = -1;
        for (int off = 1; off <= N; off++) begin
            int c = (m_last_r + off) % N;
            if (a < 0 && rvalid[c] && c != m_prev_r) a = c;
        end
        m_prev_r = a;
        e_ack = '0;
        e_upd = 0;
        cmpv = clr ? 10'h3FF : m_best_bits;
        if (a >= 0) begin
            e_ack[a] = 1'b1;
            m_last_r = a;
            bo = rbits[10*a +: 10];
        end else begin
            bo = 10'h3FF;
        end
        if (a >= 0 && bo < cmpv) begin
            m_best_bits = bo; m_best_nonce = rnonce[256*a +: 256]; e_upd = 1;
        end else if (clr) begin
            m_best_bits = 10'h3FF; m_best_nonce = 256'd0;
        end
        m_run = stop ? 1'b0 : (start ? 1'b1 : m_run);
    endtask

    task automatic check_all();
        check_eq("running", running, m_run);
        check_eq("grant", grant, e_grant);
        if (e_grant != '0) check_eq("work_nonce", wnonce, e_wnonce);
        check_eq("ack", ack, e_ack);
        check_eq("best_nonce", best_nonce, m_best_nonce);
        check_eq("best_bits", best_bits, m_best_bits);
        check_eq("best_update", upd, e_upd);
    endtask

    // one clock: model follows the edge, outputs compared 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check_eq("rst_work_nonce", wnonce, 256'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    logic [255:0] n3, n2, b;
    logic [N-1:0] oh;

    initial begin
        rst = 1'b1; start = 0; stop = 0; clr = 0; base = 256'd0;
        req = '0; rvalid = '0; rnonce = '0; rbits = '0;
        @(negedge clk);
        do_reset();

        // basic grant and block stepping
        base = 256'h100; start = 1'b1; cycle();
        req = 4'b0100; cycle();
        check_eq("t1_grant", grant, 4'b0100);
        check_eq("t1_nonce", wnonce, 256'h100);
        req = '0; cycle();
        req = 4'b0100; cycle();
        check_eq("t1_nonce2", wnonce, 256'h10100);
        req = '0; cycle();

        // all cores requesting: strict round-robin
        do_reset();
        b = rand256(); base = b; start = 1'b1; cycle();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            oh = '0; oh[k % N] = 1'b1;
            check_eq("rr_order", grant, oh);
            check_eq("rr_nonce", wnonce, b + 256'(k) * 256'h10000);
        end
        req = '0; cycle();

        // wrap at 2^256
        do_reset();
        base = {{240{1'b1}}, 16'h0000}; start = 1'b1; cycle();
        req = 4'b0001; cycle();
        check_eq("wrap_first", wnonce, {{240{1'b1}}, 16'h0000});
        req = '0; cycle();
        req = 4'b0001; cycle();
        check_eq("wrap_zero", wnonce, 256'd0);
        req = '0; cycle();

        // results: two cores at once, then a tie
        do_reset();
        n3 = rand256();
        rnonce = {n3, rand256(), rand256(), rand256()};
        rbits = {10'd390, 10'd0, 10'd400, 10'd0};
        rvalid = 4'b1010; cycle();
        check_eq("res_ack1", ack, 4'b0010);
        check_eq("res_bits1", best_bits, 10'd400);
        check_eq("res_upd1", upd, 1'b1);
        rvalid = 4'b1000; cycle();
        check_eq("res_ack2", ack, 4'b1000);
        check_eq("res_bits2", best_bits, 10'd390);
        check_eq("res_nonce2", best_nonce, n3);
        check_eq("res_upd2", upd, 1'b1);
        rvalid = '0; cycle();
        rbits = {10'd0, 10'd0, 10'd0, 10'd390}; rvalid = 4'b0001; cycle();
        check_eq("tie_ack", ack, 4'b0001);
        check_eq("tie_upd", upd, 1'b0);
        check_eq("tie_nonce", best_nonce, n3);
        rvalid = '0; cycle();

        // clear with and without a result
        n2 = rand256();
        rnonce[256*2 +: 256] = n2; rbits[10*2 +: 10] = 10'd500;
        rvalid = 4'b0100; clr = 1'b1; cycle();
        check_eq("clr_res_bits", best_bits, 10'd500);
        check_eq("clr_res_nonce", best_nonce, n2);
        check_eq("clr_res_upd", upd, 1'b1);
        rvalid = '0; clr = 1'b1; cycle();
        check_eq("clr_bits", best_bits, 10'h3FF);
        check_eq("clr_nonce", best_nonce, 256'd0);
        check_eq("clr_upd", upd, 1'b0);

        // stop with requests pending; results still served
        start = 1'b1; cycle();
        req = 4'b1111; stop = 1'b1; rvalid = 4'b0010; rbits[10*1 +: 10] = 10'd5; cycle();
        check_eq("stop_grant", grant, 4'b0000);
        check_eq("stop_ack", ack, 4'b0010);
        check_eq("stop_running", running, 1'b0);
        rvalid = '0; cycle();
        check_eq("idle_grant", grant, 4'b0000);

        // reset in the middle of RUN
        start = 1'b1; cycle(); cycle();
        do_reset();
        req = '0;

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 23) == 0);
            clr   = ($urandom_range(0, 31) == 0);
            base  = ($urandom_range(0, 3) == 0) ? ({256{1'b1}} - 256'($urandom_range(0, 3)) * 256'h10000)
                                                 : rand256();
            req    = N'($urandom);
            rvalid = N'($urandom);
            rnonce = {rand256(), rand256(), rand256(), rand256()};
            for (int k = 0; k < N; k++) rbits[10*k +: 10] = 10'($urandom_range(0, 1023));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
